// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command, ALU and result signals of the ALU sequencer.
interface alu_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic [31:0] alu_x;
   logic [31:0] alu_y;
   logic [15:0] alu_op;
   logic [63:0] alu_z;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_lo;
   logic [31:0] res_hi;
   logic        res_err;
   logic        busy;
   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, alu_z, res_ready,
      input  cmd_ready, alu_x, alu_y, alu_op, res_valid, res_lo, res_hi, res_err, busy
   );
   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_z, res_ready,
      output cmd_ready, alu_x, alu_y, alu_op, res_valid, res_lo, res_hi, res_err, busy
   );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one command at a time to a multi-cycle ALU and holds the result until taken.
module alu_sequencer #(
   parameter int DIV_CYCLES = 34
) (
   input logic           clk,
   input logic           reset,
   alu_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, WAIT_DIV, DONE} state_t;
   state_t      r_state, w_next;
   logic [3:0]  r_op;
   logic [31:0] r_x, r_y, r_lo, r_hi, r_cnt;
   logic        r_err;
   logic        w_accept, w_legal, w_cnt_done, w_capture;
   assign w_accept   = r_state == IDLE && bus.cmd_valid;
   assign w_legal    = bus.cmd_op < 4'd14;
   assign w_cnt_done = r_cnt == 32'(DIV_CYCLES - 1);
   assign w_capture  = r_state == EXEC || (r_state == WAIT_DIV && w_cnt_done);
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (bus.cmd_valid) w_next = !w_legal ? DONE : bus.cmd_op == 4'd4 ? WAIT_DIV : EXEC;
         EXEC:     w_next = DONE;
         WAIT_DIV: if (w_cnt_done) w_next = DONE;
         DONE:     if (bus.res_ready) w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end
   always_comb begin
      bus.cmd_ready = r_state == IDLE;
      bus.busy      = r_state != IDLE;
      bus.res_valid = r_state == DONE;
      bus.alu_op    = (r_state == EXEC || r_state == WAIT_DIV) ? 16'(1) << r_op : 16'h0;
      bus.alu_x     = r_x;
      bus.alu_y     = r_y;
      bus.res_lo    = r_lo;
      bus.res_hi    = r_hi;
      bus.res_err   = r_err;
   end
   // Operands load only for legal ops so alu_x/alu_y keep their previous values around an illegal command.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op  <= '0;
         r_x   <= '0;
         r_y   <= '0;
         r_cnt <= '0;
         r_lo  <= '0;
         r_hi  <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op  <= bus.cmd_op;
            r_cnt <= '0;
            if (w_legal) begin
               r_x <= bus.cmd_a;
               r_y <= bus.cmd_b;
            end else begin
               r_lo  <= '0;
               r_hi  <= '0;
               r_err <= 1'b1;
            end
         end else if (r_state == WAIT_DIV) begin
            r_cnt <= r_cnt + 32'd1;
         end
         if (w_capture) begin
            {r_hi, r_lo} <= bus.alu_z;
            r_err        <= 1'b0;
         end
      end
   end
endmodule
